// File: rtl/slave_spi_param.sv
// SPI slave clocked directly by sck. It receives one WIDTH-bit word on mosi
// while it returns data_in on miso. Words can follow each other with no gap
// while ss stays low. Each completed word goes to the local logic as a
// data_out/rx_valid pair. If the local logic is busy, the word is dropped
// and the sticky overrun flag is set.
module slave_spi_param #(
    parameter  int WIDTH     = 8,
    parameter  int LSB_FIRST = 1,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             ss,
    input  logic             en,
    input  logic             mosi,
    output logic             miso,
    input  logic             busy,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_valid,
    output logic             overrun,
    output logic             irq,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rx_sr, rx_d;
    logic [WIDTH-1:0] tx_sr, tx_d;
    logic [CNT_W-1:0] cnt_d;
    logic             miso_d;
    logic [WIDTH-1:0] dout_d;
    logic             vld_d;
    logic             ovr_d;
    logic [WIDTH-1:0] rx_word;

    // Bit that leaves first for the configured bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
    endfunction

    // Move the next tx bit into the first_bit position.
    function automatic logic [WIDTH-1:0] tx_shift(input logic [WIDTH-1:0] v);
        return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
    endfunction

    // Shift one received bit in. After WIDTH shifts, the first bit that
    // arrived sits at bit 0 (LSB first) or at bit WIDTH-1 (MSB first). Any
    // stale content has been pushed out, so no clear is needed between words.
    function automatic logic [WIDTH-1:0] rx_shift(input logic [WIDTH-1:0] v,
                                                  input logic             b);
        return (LSB_FIRST != 0) ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
    endfunction

    // The word as it stands once this edge's mosi bit is included.
    assign rx_word = rx_shift(rx_sr, mosi);

    // State register.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and datapath decode. An edge that starts a word is taken
    // both from IDLE and from the edge right after a completed word. That
    // second case is what makes back-to-back words possible.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_cnt;
        rx_d    = rx_sr;
        tx_d    = tx_sr;
        miso_d  = 1'b0;
        dout_d  = data_out;
        vld_d   = 1'b0;
        ovr_d   = overrun;

        unique case (state_q)
            IDLE: begin
                if (!ss && en) begin
                    state_d = SHIFT;
                    tx_d    = tx_shift(data_in);
                    miso_d  = first_bit(data_in);
                    rx_d    = rx_word;
                    cnt_d   = CNT_ONE;
                end
            end

            SHIFT: begin
                if (ss) begin
                    // Abort: the partial word is discarded without a trace.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bit_cnt == '0) begin
                    // Word boundary. Start the next word, or leave once en
                    // has dropped. en is only looked at here, so a word
                    // that is already running is never cut short.
                    if (en) begin
                        tx_d   = tx_shift(data_in);
                        miso_d = first_bit(data_in);
                        rx_d   = rx_word;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tx_d   = tx_shift(tx_sr);
                    miso_d = first_bit(tx_sr);
                    rx_d   = rx_word;
                    if (bit_cnt == LAST_BIT) begin
                        cnt_d = '0;
                        if (!busy) begin
                            dout_d = rx_word;
                            vld_d  = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = bit_cnt + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath registers. rx_valid is rebuilt on every edge, so it can
    // never last longer than one sck cycle.
    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            miso     <= 1'b0;
            data_out <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            bit_cnt  <= cnt_d;
            rx_sr    <= rx_d;
            tx_sr    <= tx_d;
            miso     <= miso_d;
            data_out <= dout_d;
            rx_valid <= vld_d;
            overrun  <= ovr_d;
        end
    end

    assign irq = rx_valid | overrun;

endmodule

// File: tb/tb_slave_spi_param.sv
// Directed bench for slave_spi_param. It runs an 8-bit LSB-first instance
// and a 16-bit MSB-first instance off the same sck and reset.
module tb_slave_spi_param;

    logic        sck = 1'b0;
    logic        rst = 1'b0;

    logic        ss8 = 1'b1, en8 = 1'b0, mosi8 = 1'b0, busy8 = 1'b0;
    logic [7:0]  data_in8 = '0;
    logic        miso8, rx_valid8, overrun8, irq8;
    logic [7:0]  data_out8;
    logic [2:0]  bit_cnt8;

    logic        ss16 = 1'b1, en16 = 1'b0, mosi16 = 1'b0, busy16 = 1'b0;
    logic [15:0] data_in16 = '0;
    logic        miso16, rx_valid16, overrun16, irq16;
    logic [15:0] data_out16;
    logic [3:0]  bit_cnt16;

    int checks = 0;
    int errors = 0;

    always #5 sck = ~sck;

    slave_spi_param #(.WIDTH(8), .LSB_FIRST(1)) dut8 (
        .sck(sck), .rst(rst), .ss(ss8), .en(en8), .mosi(mosi8), .miso(miso8),
        .busy(busy8), .data_in(data_in8), .data_out(data_out8),
        .rx_valid(rx_valid8), .overrun(overrun8), .irq(irq8), .bit_cnt(bit_cnt8)
    );

    slave_spi_param #(.WIDTH(16), .LSB_FIRST(0)) dut16 (
        .sck(sck), .rst(rst), .ss(ss16), .en(en16), .mosi(mosi16), .miso(miso16),
        .busy(busy16), .data_in(data_in16), .data_out(data_out16),
        .rx_valid(rx_valid16), .overrun(overrun16), .irq(irq16), .bit_cnt(bit_cnt16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sck edge on dut8 with the given pins, sampled 1ns after posedge.
    task automatic edge8(input logic s, input logic e, input logic m);
        @(negedge sck);
        ss8 = s; en8 = e; mosi8 = m;
        @(posedge sck);
        #1;
    endtask

    // Full LSB-first word on dut8. en drops from bit en_off onward.
    task automatic word8(input logic [7:0] w, input logic [7:0] din,
                         input logic b, input int en_off);
        for (int i = 0; i < 8; i++) begin
            @(negedge sck);
            ss8 = 1'b0; en8 = (i < en_off); mosi8 = w[i];
            data_in8 = din; busy8 = b;
            @(posedge sck);
            #1;
            chk("miso8", 32'(miso8), 32'(din[i]));
            chk("rx_valid8", 32'(rx_valid8), 32'(i == 7 && !b));
        end
    endtask

    // Full MSB-first word on dut16.
    task automatic word16(input logic [15:0] w, input logic [15:0] din);
        for (int i = 0; i < 16; i++) begin
            @(negedge sck);
            ss16 = 1'b0; en16 = 1'b1; mosi16 = w[15-i];
            data_in16 = din; busy16 = 1'b0;
            @(posedge sck);
            #1;
            chk("miso16", 32'(miso16), 32'(din[15-i]));
            chk("rx_valid16", 32'(rx_valid16), 32'(i == 15));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge sck);
        #1;
        chk("rst_miso", 32'(miso8), 32'h0);
        chk("rst_data_out", 32'(data_out8), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid8), 32'h0);
        chk("rst_overrun", 32'(overrun8), 32'h0);
        chk("rst_irq", 32'(irq8), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt8), 32'h0);
        chk("rst_data_out16", 32'(data_out16), 32'h0);
        @(negedge sck);
        rst = 1'b1;
        edge8(1'b1, 1'b1, 1'b0);
        chk("idle_miso", 32'(miso8), 32'h0);

        // 0xA5 in, 0x3C out, LSB first
        word8(8'hA5, 8'h3C, 1'b0, 8);
        chk("t1_data_out", 32'(data_out8), 32'hA5);
        chk("t1_irq", 32'(irq8), 32'h1);
        chk("t1_bit_cnt", 32'(bit_cnt8), 32'h0);
        edge8(1'b1, 1'b1, 1'b0);
        chk("t1_rx_valid_clr", 32'(rx_valid8), 32'h0);
        chk("t1_irq_clr", 32'(irq8), 32'h0);
        chk("t1_miso_idle", 32'(miso8), 32'h0);

        // 16-bit MSB first: 0x1234 in, 0xBEEF out
        word16(16'h1234, 16'hBEEF);
        chk("t2_data_out16", 32'(data_out16), 32'h1234);
        chk("t2_irq16", 32'(irq16), 32'h1);
        @(negedge sck);
        ss16 = 1'b1;
        @(posedge sck);
        #1;
        chk("t2_rx_valid16_clr", 32'(rx_valid16), 32'h0);
        chk("t2_overrun16", 32'(overrun16), 32'h0);

        // Back-to-back 0x11/0x55 then 0x22/0xAA; en drops mid second word
        word8(8'h11, 8'h55, 1'b0, 8);
        chk("t3_data_out_a", 32'(data_out8), 32'h11);
        word8(8'h22, 8'hAA, 1'b0, 4);
        chk("t3_data_out_b", 32'(data_out8), 32'h22);
        edge8(1'b0, 1'b0, 1'b1);
        chk("t3_en_off_bit_cnt", 32'(bit_cnt8), 32'h0);
        chk("t3_en_off_miso", 32'(miso8), 32'h0);
        chk("t3_en_off_rx_valid", 32'(rx_valid8), 32'h0);
        edge8(1'b0, 1'b0, 1'b1);
        chk("t3_idle_bit_cnt", 32'(bit_cnt8), 32'h0);
        chk("t3_idle_data_out", 32'(data_out8), 32'h22);
        edge8(1'b1, 1'b1, 1'b0);

        // Fresh reset, then 0x7E with busy=1
        @(negedge sck);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        word8(8'h7E, 8'h00, 1'b1, 8);
        chk("t4_data_out", 32'(data_out8), 32'h00);
        chk("t4_overrun", 32'(overrun8), 32'h1);
        chk("t4_irq", 32'(irq8), 32'h1);
        edge8(1'b1, 1'b1, 1'b0);
        chk("t4_overrun_sticky", 32'(overrun8), 32'h1);
        chk("t4_irq_sticky", 32'(irq8), 32'h1);

        // Abort after 5 bits of 0xFF, then 0x81
        for (int i = 0; i < 5; i++) edge8(1'b0, 1'b1, 1'b1);
        chk("t5_bit_cnt_mid", 32'(bit_cnt8), 32'h5);
        edge8(1'b1, 1'b1, 1'b1);
        chk("t5_rx_valid", 32'(rx_valid8), 32'h0);
        chk("t5_bit_cnt", 32'(bit_cnt8), 32'h0);
        chk("t5_miso", 32'(miso8), 32'h0);
        chk("t5_data_out", 32'(data_out8), 32'h00);
        chk("t5_overrun", 32'(overrun8), 32'h1);
        word8(8'h81, 8'h5A, 1'b0, 8);
        chk("t5_data_out_next", 32'(data_out8), 32'h81);
        edge8(1'b1, 1'b1, 1'b0);

        // Async reset after 3 bits, then 0xC3
        for (int i = 0; i < 3; i++) edge8(1'b0, 1'b1, 1'b1);
        chk("t6_bit_cnt_mid", 32'(bit_cnt8), 32'h3);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_miso", 32'(miso8), 32'h0);
        chk("t6_data_out", 32'(data_out8), 32'h0);
        chk("t6_rx_valid", 32'(rx_valid8), 32'h0);
        chk("t6_overrun", 32'(overrun8), 32'h0);
        chk("t6_irq", 32'(irq8), 32'h0);
        chk("t6_bit_cnt", 32'(bit_cnt8), 32'h0);
        chk("t6_data_out16", 32'(data_out16), 32'h0);
        #1;
        rst = 1'b1;
        word8(8'hC3, 8'h96, 1'b0, 8);
        chk("t6_data_out_next", 32'(data_out8), 32'hC3);
        chk("t6_overrun_next", 32'(overrun8), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
